jk_counter_driver: RTL

- Controller end of the JK flip-flop interface: generates per-bit J/K excitation for an external bank of WIDTH JK flip-flops.
- Makes the bank behave as a programmable modulo-M up/down counter.
- Keeps a shadow copy of the expected bank state and checks the bank's Q feedback every cycle. Any divergence is flagged.
- Sits beside the JK flip-flop bank. Its j/k vectors wire directly to the bank's j/k inputs, and the bank's q vector returns on q_fb.

---
 rtl/jk_counter_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jk_counter_driver.sv
// Drives J/K excitation for an external bank of WIDTH JK flip-flops so the bank counts modulo M,
// and cross-checks the bank's Q feedback against a shadow count. `define JK_TOGGLE_EXC_EN selects toggle excitation.
module jk_counter_driver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] mod_reg;
    logic             wrap_reg;
    logic             err_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] term_val;
    logic             wrap_next;

    // mod_reg==0 gives all-ones here, i.e. a full 2^WIDTH cycle.
    assign term_val = mod_reg - ONE;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (state_reg == ST_RUN) begin
            if (up_dn) begin
                count_next = (count_reg >= term_val) ? '0 : count_reg + ONE;
                wrap_next  = (count_reg == term_val);
            end else begin
                count_next = (count_reg == '0) ? term_val : count_reg - ONE;
                wrap_next  = (count_reg == '0);
            end
        end
    end

    // Excitation follows count_next, so the bank and the shadow move on the same edge.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
            logic chg;
            assign chg = count_reg[gi] ^ count_next[gi];
`ifdef JK_TOGGLE_EXC_EN
            assign j[gi] = chg;
            assign k[gi] = chg;
`else
            assign j[gi] = chg & count_next[gi];
            assign k[gi] = chg & ~count_next[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            mod_reg   <= '0;
            wrap_reg  <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;
            if (state_reg != ST_ERROR) begin
                if (q_fb != count_reg) begin
                    state_reg <= ST_ERROR;
                    err_reg   <= 1'b1;
                    busy_reg  <= 1'b0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            if (start && !stop) begin
                                state_reg <= ST_RUN;
                                mod_reg   <= modulus;
                                busy_reg  <= 1'b1;
                            end
                        end
                        ST_RUN: begin
                            count_reg <= count_next;
                            wrap_reg  <= wrap_next;
                            if (stop) begin
                                state_reg <= ST_HOLD;
                                busy_reg  <= 1'b0;
                            end
                        end
                        ST_HOLD: begin
                            if (start && !stop) begin
                                state_reg <= ST_RUN;
                                busy_reg  <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= ST_ERROR;
                        end
                    endcase
                end
            end
        end
    end

    assign count = count_reg;
    assign busy  = busy_reg;
    assign wrap  = wrap_reg;
    assign err   = err_reg;

endmodule
